// File: rtl/imm_expand_pipe.sv
// imm_expand_pipe: two-stage elastic SPU immediate expander.
//   S1 extracts the I7/I10/I16/I18 field, sign/zero-extends it and trims it
//      to the lane width; S2 replicates the lane value across VEC_W bits.
// Optional feature macro: IMM_UPPER_EN adds the in_upper port (ilhu form,
// {I16, 16'h0000} per word lane).
// Handshake: a beat moves on a clock edge where valid && ready are both high;
// once out_valid is raised, out_imm/out_tag hold until out_ready accepts them.
module imm_expand_pipe #(
    parameter int VEC_W = 128,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [1:0]       in_fmt,
    input  logic             in_zext,
    input  logic [1:0]       in_elem,
`ifdef IMM_UPPER_EN
    input  logic             in_upper,
`endif
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (VEC_W % 32 != 0) begin : g_bad_vec_w
            $error("imm_expand_pipe: VEC_W must be a multiple of 32");
        end
    endgenerate

    logic upper_sel;
`ifdef IMM_UPPER_EN
    assign upper_sel = in_upper;
`else
    assign upper_sel = 1'b0;
`endif

    // Instruction bits outside every immediate field are never looked at.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{in_inst[31:25], in_inst[6:0]};

    // Pipeline state
    logic             s1_valid_q, s1_valid_d;
    logic [VEC_W-1:0] s1_val_q,   s1_val_d;
    logic [1:0]       s1_elem_q,  s1_elem_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic [VEC_W-1:0] out_imm_q,  out_imm_d;
    logic [TAG_W-1:0] out_tag_q,  out_tag_d;

    logic             s2_adv, s1_adv;
    logic             s1_load, s2_load;
    logic             ext_fill;
    logic [15:0]      field_lo16;
    logic [VEC_W-1:0] ext_val;
    logic [VEC_W-1:0] lane_val;
    logic [VEC_W-1:0] rep_val;

    // Stage 1 datapath: select the field, extend it, trim to the lane width.
    always_comb begin
        ext_fill   = 1'b0;
        field_lo16 = 16'd0;
        ext_val    = '0;
        case (in_fmt)
            2'b00: begin
                ext_fill   = ~in_zext & in_inst[20];
                field_lo16 = {9'd0, in_inst[20:14]};
            end
            2'b01: begin
                ext_fill   = ~in_zext & in_inst[23];
                field_lo16 = {6'd0, in_inst[23:14]};
            end
            2'b10: begin
                ext_fill   = ~in_zext & in_inst[22];
                field_lo16 = in_inst[22:7];
            end
            default: begin
                ext_fill   = ~in_zext & in_inst[24];
                field_lo16 = in_inst[22:7];
            end
        endcase
        ext_val = {VEC_W{ext_fill}};
        case (in_fmt)
            2'b00:   ext_val[6:0]  = in_inst[20:14];
            2'b01:   ext_val[9:0]  = in_inst[23:14];
            2'b10:   ext_val[15:0] = in_inst[22:7];
            default: ext_val[17:0] = in_inst[24:7];
        endcase
        case (in_elem)
            2'b00:   lane_val = ext_val;
            2'b01:   lane_val = VEC_W'(ext_val[31:0]);
            2'b10:   lane_val = VEC_W'(ext_val[15:0]);
            default: lane_val = VEC_W'(ext_val[7:0]);
        endcase
        // ilhu form: immediate lands in the upper halfword of each word.
        if (upper_sel && in_elem == 2'b01) begin
            lane_val = VEC_W'({field_lo16, 16'h0000});
        end
    end

    // Stage 2 datapath: replicate the S1 lane value across the whole vector.
    always_comb begin
        rep_val = '0;
        case (s1_elem_q)
            2'b00: rep_val = s1_val_q;
            2'b01: for (int i = 0; i < VEC_W / 32; i++) rep_val[i*32 +: 32] = s1_val_q[31:0];
            2'b10: for (int i = 0; i < VEC_W / 16; i++) rep_val[i*16 +: 16] = s1_val_q[15:0];
            default: for (int i = 0; i < VEC_W / 8; i++) rep_val[i*8 +: 8] = s1_val_q[7:0];
        endcase
    end

    // Elastic control and next-state: each stage loads only when it advances;
    // flush clears valids but leaves the output data registers untouched.
    always_comb begin
        s2_adv  = !s2_valid_q || out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        s1_load = s1_adv && in_valid && !flush;
        s2_load = s2_adv && s1_valid_q && !flush;

        s1_valid_d = flush ? 1'b0 : (s1_adv ? in_valid   : s1_valid_q);
        s2_valid_d = flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);

        s1_val_d  = s1_val_q;
        s1_elem_d = s1_elem_q;
        s1_tag_d  = s1_tag_q;
        if (s1_load) begin
            s1_val_d  = lane_val;
            s1_elem_d = in_elem;
            s1_tag_d  = in_tag;
        end

        out_imm_d = out_imm_q;
        out_tag_d = out_tag_q;
        if (s2_load) begin
            out_imm_d = rep_val;
            out_tag_d = s1_tag_q;
        end
    end

    // Pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_val_q   <= '0;
            s1_elem_q  <= 2'b00;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            out_imm_q  <= '0;
            out_tag_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_val_q   <= s1_val_d;
            s1_elem_q  <= s1_elem_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            out_imm_q  <= out_imm_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;

endmodule
